// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready in, valid/ready out plus flags.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, zero, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, result_hi, carry, zero, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with iterative shift-add multiply and barrel shifts.
// States: IDLE accepts operands | BUSY runs multiply iterations | DONE holds result until drained.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHW-1:0]     amt;
  logic               shift_out;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  // Shift amount is b modulo WIDTH; a nonzero multiple of WIDTH shifts every bit out.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    amt       = bus.b[SHW-1:0];
    shift_out = (amt == '0) && ((bus.b >> SHW) != '0);
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: alu_res = shift_out ? '0 : (bus.a << amt);
      OP_SHR: alu_res = shift_out ? '0 : (bus.a >> amt);
      default: alu_res = '0;
    endcase
    acc_next = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.carry     <= 1'b0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      mcand         <= '0;
      acc           <= '0;
      mplier        <= '0;
      count         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            if (bus.op == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              acc    <= '0;
              count  <= CW'(WIDTH);
              state  <= BUSY;
            end else begin
              bus.result    <= alu_res;
              bus.result_hi <= '0;
              bus.carry     <= alu_c;
              bus.overflow  <= alu_v;
              bus.zero      <= (alu_res == '0);
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            bus.result    <= acc_next[WIDTH-1:0];
            bus.result_hi <= acc_next[2*WIDTH-1:WIDTH];
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= (acc_next == '0);
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
